fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//   Instruction fetch front end: initiator side of the synchronous-read instruction ROM.
//   Owns the PC and drives the ROM address. Absorbs the ROM's fixed 1-cycle read latency.
//   Delivers {instr, pc} to decode over a valid/ready handshake, and accepts branch
//   redirects from execute. Sits between the instruction ROM and the decoder in the CPU core.
// PARAMETERS
//   ADDR_WIDTH  5          ROM word-address width; PC is a word address, wraps modulo 2**ADDR_WIDTH
//   WIDTH       32         instruction word width (matches ROM data width)
//   RESET_PC    0          PC value loaded on reset
// PORTS
//   clk          in   1           single clock, all state on posedge
//   rst          in   1           asynchronous, active-high reset
//   rom_addr     out  ADDR_WIDTH  ROM read address; sampled by ROM at posedge
//   rom_q        in   WIDTH       ROM data; valid the cycle after the address was presented
//   instr        out  WIDTH       instruction at head of output buffer
//   instr_pc     out  ADDR_WIDTH  word address of instr
//   instr_valid  out  1           head entry valid
//   instr_ready  in   1           decode accepts head; pop = instr_valid & instr_ready
//   br_valid     in   1           redirect request; single-cycle pulse, honoured every cycle it is high
//   br_target    in   ADDR_WIDTH  redirect word address
//   perf_fetched out  32          only when FETCH_PERF_EN is defined (see CONFIGURATION)
// BEHAVIOUR
//   State: pc (next address to issue); inflight flag plus inflight_pc; 2-entry buffer with count 0..2.
//   Reset (async): pc=RESET_PC, inflight=0, count=0.
//     Outputs: instr_valid=0, instr=0, instr_pc=0, rom_addr=RESET_PC.
//   Issue rule: issue = (count - pop + inflight) <= 1.
//     rom_addr = pc (combinational from pc register).
//     On issue: inflight<=1, inflight_pc<=pc, pc<=pc+1 (wraps 2**ADDR_WIDTH-1 -> 0).
//     No issue: inflight<=0; rom_addr still shows pc. A repeated read is harmless.
//   Arrival: when inflight=1, rom_q/inflight_pc are written into the buffer tail this cycle.
//     Issue rule guarantees the buffer never overflows.
//   Output: instr/instr_pc/instr_valid are registered from the buffer head.
//     No combinational path from rom_q or instr_ready to outputs.
//   Latency:
//     reset deassert -> first instr_valid = 2 cycles.
//     instr_ready held high -> 1 instr/cycle, sequential PCs.
//   Stall: instr_ready=0 holds head stable; buffer fills to 2 and issue stops.
//     No instruction is lost or duplicated.
//   Redirect (br_valid=1 in cycle t), highest priority:
//     buffer flushed (count<=0); the response arriving in cycle t is discarded.
//     A pop in cycle t is ignored: the head is dropped, not consumed.
//     rom_addr=br_target in cycle t, issue forced, pc<=br_target+1 (wraps).
//     Target instr is valid from cycle t+2.
//     Back-to-back redirects: the last one wins.
//   Reset mid-operation clears everything immediately; in-flight data is discarded.
// CONFIGURATION
//   `define FETCH_PERF_EN
//     Adds port perf_fetched[31:0]: counts pops, wraps at 2**32, reset 0.
//     Pops ignored under redirect are not counted.
//   Undefined: port and counter absent; no other behaviour differs.
// STRUCTURE
//   cpu_defs.vh (shared include): instruction WIDTH, ADDR_WIDTH, RESET_PC defaults.
//   Sub-module fetch_skid_buf: 2-entry FIFO {WIDTH+ADDR_WIDTH} with count, push/pop/flush.
//   fetch_unit keeps the PC, inflight tracking, issue rule and redirect logic.
// TESTING
//   Bench uses a behavioural 1-cycle-latency ROM with mem[i]=32'hA000_0000+i.
//   1. Reset, instr_ready=1 -> instr_valid rises cycle 2; instr=A0000000,A0000001,... pc 0,1,2 each cycle.
//   2. ready=0 for 5 cycles after pc=3 shown -> head stays A0000003.
//      Release: 3,4,5 in order, no gaps or duplicates.
//   3. br_valid with target=0x10 while buffer full -> valid=0 at t+1.
//      At t+2: instr=A0000010, pc=0x10, then 0x11.
//   4. Wrap: target=0x1E, ready=1 -> pc sequence 1E,1F,00,01.
//   5. Async rst asserted mid-stream (off clock edge) -> instr_valid=0 immediately.
//      After release, fetch restarts from pc=0.
//   6. FETCH_PERF_EN: 10 pops plus 1 pop coincident with redirect -> perf_fetched=10.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared defaults and helpers for the instruction fetch front end.
// Widths here must match the instruction ROM and decoder.
package fetch_unit_pkg;

    localparam int FU_ADDR_W   = 5;
    localparam int FU_WIDTH    = 32;
    localparam int FU_RESET_PC = 0;

    // Issue only if the new word is guaranteed a free buffer slot on arrival.
    function automatic logic issue_ok(
        input logic [1:0] cnt,
        input logic       pop,
        input logic       infl
    );
        logic [2:0] occ;
        occ = {1'b0, cnt} - {2'b0, pop} + {2'b0, infl};
        return occ <= 3'd1;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch bus: ROM read port, decode handshake and branch redirect.
// master = fetch unit side, slave = ROM/decode/execute side.
interface fetch_unit_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int WIDTH      = 32
) ();

    logic [ADDR_WIDTH-1:0] rom_addr;
    logic [WIDTH-1:0]      rom_q;
    logic [WIDTH-1:0]      instr;
    logic [ADDR_WIDTH-1:0] instr_pc;
    logic                  instr_valid;
    logic                  instr_ready;
    logic                  br_valid;
    logic [ADDR_WIDTH-1:0] br_target;

    modport master (
        output rom_addr,
        input  rom_q,
        output instr,
        output instr_pc,
        output instr_valid,
        input  instr_ready,
        input  br_valid,
        input  br_target
    );

    modport slave (
        input  rom_addr,
        output rom_q,
        input  instr,
        input  instr_pc,
        input  instr_valid,
        output instr_ready,
        output br_valid,
        output br_target
    );

endinterface

// File: rtl/fetch_skid_buf.sv
// Two-entry shift FIFO; slot 0 is always the head and drives the outputs
// straight from flops, so nothing combinational reaches decode.
module fetch_skid_buf #(
    parameter int W = 37
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         flush_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] dout_o,
    output logic         valid_o,
    output logic [1:0]   count_o
);

    logic [W-1:0] e0_q, e0_d;
    logic [W-1:0] e1_q, e1_d;
    logic         v0_q, v0_d;
    logic         v1_q, v1_d;

    always_comb begin
        e0_d = e0_q;
        e1_d = e1_q;
        v0_d = v0_q;
        v1_d = v1_q;
        if (flush_i) begin
            v0_d = 1'b0;
            v1_d = 1'b0;
        end else begin
            if (pop_i && v0_q) begin
                e0_d = e1_q;
                v0_d = v1_q;
                v1_d = 1'b0;
            end
            if (push_i) begin
                if (!v0_d) begin
                    e0_d = din_i;
                    v0_d = 1'b1;
                end else begin
                    e1_d = din_i;
                    v1_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e0_q <= '0;
            e1_q <= '0;
            v0_q <= 1'b0;
            v1_q <= 1'b0;
        end else begin
            e0_q <= e0_d;
            e1_q <= e1_d;
            v0_q <= v0_d;
            v1_q <= v1_d;
        end
    end

    assign dout_o  = e0_q;
    assign valid_o = v0_q;
    assign count_o = v1_q ? 2'd2 : (v0_q ? 2'd1 : 2'd0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, ROM issue/inflight tracking and branch redirect.
// Optional FETCH_PERF_EN adds perf_fetched, a count of accepted pops.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = FU_ADDR_W,
    parameter int WIDTH      = FU_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC =
        ADDR_WIDTH'(FU_RESET_PC)
) (
    input  logic          clk,
    input  logic          rst,
    fetch_unit_if.master  f
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]   perf_fetched
`endif
);

    localparam int EW = WIDTH + ADDR_WIDTH;

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] infl_pc_q, infl_pc_d;
    logic                  infl_q, infl_d;
    logic                  pop;
    logic                  issue;
    logic                  br;
    logic [1:0]            count;
    logic [EW-1:0]         head;
    logic                  head_v;

    assign br  = f.br_valid;
    assign pop = head_v & f.instr_ready;

    always_comb begin
        issue     = br | issue_ok(count, pop, infl_q);
        f.rom_addr = br ? f.br_target : pc_q;
        infl_d    = issue;
        infl_pc_d = issue ? f.rom_addr : infl_pc_q;
        pc_d      = issue ? f.rom_addr + 1'b1 : pc_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            infl_q    <= 1'b0;
            infl_pc_q <= '0;
        end else begin
            pc_q      <= pc_d;
            infl_q    <= infl_d;
            infl_pc_q <= infl_pc_d;
        end
    end

    // A redirect flushes the buffer and drops any pop or arrival this cycle.
    fetch_skid_buf #(.W(EW)) u_buf (
        .clk     (clk),
        .rst     (rst),
        .push_i  (infl_q),
        .pop_i   (pop & ~br),
        .flush_i (br),
        .din_i   ({f.rom_q, infl_pc_q}),
        .dout_o  (head),
        .valid_o (head_v),
        .count_o (count)
    );

    assign f.instr       = head[EW-1:ADDR_WIDTH];
    assign f.instr_pc    = head[ADDR_WIDTH-1:0];
    assign f.instr_valid = head_v;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_q <= '0;
        end else if (pop && !br) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_fetched = perf_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a 1-cycle ROM, mem[i] = A000_0000 + i.
module tb_fetch_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    fetch_unit_if #(.ADDR_WIDTH(5), .WIDTH(32)) bus ();

`ifdef FETCH_PERF_EN
    logic [31:0] perf;
`endif

    fetch_unit #(.ADDR_WIDTH(5), .WIDTH(32), .RESET_PC(5'd0)) dut (
        .clk (clk),
        .rst (rst),
        .f   (bus)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched (perf)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) bus.rom_q <= 32'hA000_0000 + 32'(bus.rom_addr);

    task automatic chk_idle(input string tag);
        n_vec++;
        assert (bus.instr_valid === 1'b0) else begin
            n_err++;
            $error("FAIL %s valid got %b exp 0", tag, bus.instr_valid);
        end
    endtask

    task automatic chk_head(input string tag, input logic [4:0] pc);
        logic [37:0] got, exp;
        got = {bus.instr_valid, bus.instr, bus.instr_pc};
        exp = {1'b1, 32'hA000_0000 + 32'(pc), pc};
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s {v,instr,pc} got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic chk_addr(input string tag, input logic [4:0] a);
        n_vec++;
        assert (bus.rom_addr === a) else begin
            n_err++;
            $error("FAIL %s rom_addr got %h exp %h", tag, bus.rom_addr, a);
        end
    endtask

    initial begin
        bus.instr_ready = 1'b0;
        bus.br_valid    = 1'b0;
        bus.br_target   = '0;

        // reset state
        repeat (2) @(negedge clk);
        chk_idle("rst_valid");
        n_vec++;
        assert (bus.instr === 32'h0) else begin
            n_err++;
            $error("FAIL rst_instr got %h exp 0", bus.instr);
        end
        n_vec++;
        assert (bus.instr_pc === 5'h0) else begin
            n_err++;
            $error("FAIL rst_pc got %h exp 0", bus.instr_pc);
        end
        chk_addr("rst_addr", 5'h0);
        bus.instr_ready = 1'b1;
        rst = 1'b0;

        // 1: first valid two cycles after reset, then one per cycle
        @(negedge clk);
        chk_idle("lat_c1");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk_head("stream", 5'(i));
        end

        // 2: stall with head at pc 3
        bus.instr_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk_head("stall_hold", 5'd3);
        end
        bus.instr_ready = 1'b1;
        for (int i = 4; i < 7; i++) begin
            @(negedge clk);
            chk_head("release", 5'(i));
        end

        // 3: redirect while buffer full, with a coincident pop
        bus.instr_ready = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk_head("fill", 5'd6);
        end
        bus.br_valid    = 1'b1;
        bus.br_target   = 5'h10;
        bus.instr_ready = 1'b1;
        #1;
        chk_addr("br_addr", 5'h10);
        @(negedge clk);
        bus.br_valid = 1'b0;
        chk_idle("br_t1");
        for (int i = 16; i < 19; i++) begin
            @(negedge clk);
            chk_head("br_tgt", 5'(i));
        end

        // 4: PC wrap
        bus.br_valid  = 1'b1;
        bus.br_target = 5'h1E;
        @(negedge clk);
        bus.br_valid = 1'b0;
        chk_idle("wrap_t1");
        @(negedge clk);
        chk_head("wrap0", 5'h1E);
        @(negedge clk);
        chk_head("wrap1", 5'h1F);
        @(negedge clk);
        chk_head("wrap2", 5'h00);
        @(negedge clk);
        chk_head("wrap3", 5'h01);

        // 5: async reset off the clock edge
        #2;
        rst = 1'b1;
        #1;
        chk_idle("arst_now");
        chk_addr("arst_addr", 5'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_idle("arst_c1");
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            chk_head("restart", 5'(i));
        end

        // 6: ten pops done; one more coincident with a redirect
        bus.br_valid  = 1'b1;
        bus.br_target = 5'h05;
        @(negedge clk);
        bus.br_valid = 1'b0;
        chk_idle("br2_t1");
`ifdef FETCH_PERF_EN
        n_vec++;
        assert (perf === 32'd10) else begin
            n_err++;
            $error("FAIL perf got %0d exp 10", perf);
        end
`endif
        @(negedge clk);
        chk_head("br2_tgt", 5'h05);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
